// File: rtl/hp_bar_object_if.sv
// Pixel-scan and control bundle between the video pipeline and the HP label/bar object.
// No valid/ready pair here: pixelX/pixelY are sampled every clock, hit/heal/restart/startOfFrame
// are one-cycle pulses, and the object's outputs follow the fixed two-cycle pixel latency.
interface hp_bar_object_if;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        startOfFrame;
    logic        hit;
    logic        heal;
    logic        restart;
    logic        bitmapDrawReq;
    logic [10:0] offsetX;
    logic [10:0] offsetY;
    logic        drawingRequest;
    logic [7:0]  RGBout;
    logic [2:0]  hpValue;
    logic        dead;
    logic [1:0]  state_dbg;

    modport master (
        output pixelX, pixelY, startOfFrame, hit, heal, restart, bitmapDrawReq,
        input  offsetX, offsetY, drawingRequest, RGBout, hpValue, dead, state_dbg
    );

    modport slave (
        input  pixelX, pixelY, startOfFrame, hit, heal, restart, bitmapDrawReq,
        output offsetX, offsetY, drawingRequest, RGBout, hpValue, dead, state_dbg
    );
endinterface

// File: rtl/hp_bar_object.sv
// "HP" label driver plus segmented health bar; owns player health and the
// alive/blink/dead state machine. Two-stage pixel pipeline matches the bitmap latency.
module hp_bar_object #(
    parameter int          TOP_X        = 16,
    parameter int          TOP_Y        = 8,
    parameter int          MAX_HP       = 5,
    parameter int          BLINK_FRAMES = 32,
    parameter logic [7:0]  LABEL_COLOR  = 8'hFF,
    parameter logic [7:0]  DEAD_COLOR   = 8'hE0,
    parameter logic [7:0]  BAR_COLOR    = 8'h1C
) (
    input  logic           clk,
    input  logic           resetN,
    hp_bar_object_if.slave bus
);

    localparam int BAR_X = TOP_X + 64;

    typedef enum logic [1:0] {
        ST_ALIVE = 2'd0,
        ST_BLINK = 2'd1,
        ST_DEAD  = 2'd2
    } state_t;

    state_t      state;
    logic [2:0]  hp;
    logic        dead_q;
    logic [5:0]  frame_cnt;

    logic        in_rows;
    logic        in_label_c;
    logic        in_seg_c;
    logic        seg_filled_c;
    logic [10:0] bar_rel;
    logic [6:0]  seg_idx;

    logic        in_label1, in_seg1, seg_filled1;
    logic [10:0] offset_x_q, offset_y_q;
    logic        in_label2, in_seg2, seg_filled2, blank2;

    assign in_rows    = (bus.pixelY >= 11'(TOP_Y)) && (bus.pixelY < 11'(TOP_Y + 32));
    assign in_label_c = in_rows && (bus.pixelX >= 11'(TOP_X)) && (bus.pixelX < 11'(BAR_X));

    // Segment k sits at pitch 16 from the bar origin; the last 4 columns of each pitch are the gap.
    assign bar_rel      = bus.pixelX - 11'(BAR_X);
    assign seg_idx      = bar_rel[10:4];
    assign in_seg_c     = in_rows && (bus.pixelX >= 11'(BAR_X)) &&
                          (seg_idx < 7'(MAX_HP)) && (bar_rel[3:0] < 4'd12);
    assign seg_filled_c = seg_idx < {4'd0, hp};

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            in_label1   <= 1'b0;
            in_seg1     <= 1'b0;
            seg_filled1 <= 1'b0;
            offset_x_q  <= 11'd0;
            offset_y_q  <= 11'd0;
            in_label2   <= 1'b0;
            in_seg2     <= 1'b0;
            seg_filled2 <= 1'b0;
            blank2      <= 1'b0;
        end else begin
            in_label1   <= in_label_c;
            in_seg1     <= in_seg_c;
            seg_filled1 <= seg_filled_c;
            // Offsets are parked at 0 outside the label so the bitmap index never leaves 64x32.
            offset_x_q  <= in_label_c ? (bus.pixelX - 11'(TOP_X)) : 11'd0;
            offset_y_q  <= in_label_c ? (bus.pixelY - 11'(TOP_Y)) : 11'd0;
            in_label2   <= in_label1;
            in_seg2     <= in_seg1;
            seg_filled2 <= seg_filled1;
            blank2      <= (state == ST_BLINK) && frame_cnt[2];
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state     <= ST_ALIVE;
            hp        <= 3'(MAX_HP);
            frame_cnt <= 6'd0;
            dead_q    <= 1'b0;
        end else if (bus.restart) begin
            state     <= ST_ALIVE;
            hp        <= 3'(MAX_HP);
            frame_cnt <= 6'd0;
            dead_q    <= 1'b0;
        end else begin
            case (state)
                ST_ALIVE: begin
                    if (bus.hit) begin
                        if (hp == 3'd1) begin
                            state  <= ST_DEAD;
                            hp     <= 3'd0;
                            dead_q <= 1'b1;
                        end else begin
                            state     <= ST_BLINK;
                            hp        <= hp - 3'd1;
                            frame_cnt <= 6'(BLINK_FRAMES);
                        end
                    end else if (bus.heal && (hp < 3'(MAX_HP))) begin
                        hp <= hp + 3'd1;
                    end
                end
                ST_BLINK: begin
                    if (bus.heal && (hp < 3'(MAX_HP))) begin
                        hp <= hp + 3'd1;
                    end
                    if (bus.startOfFrame) begin
                        frame_cnt <= frame_cnt - 6'd1;
                        if (frame_cnt == 6'd1) begin
                            state <= ST_ALIVE;
                        end
                    end
                end
                ST_DEAD: begin
                    hp <= 3'd0;
                end
                default: begin
                    state <= ST_ALIVE;
                end
            endcase
        end
    end

    assign bus.offsetX        = offset_x_q;
    assign bus.offsetY        = offset_y_q;
    assign bus.drawingRequest = !blank2 && ((in_label2 && bus.bitmapDrawReq) || (in_seg2 && seg_filled2));
    assign bus.RGBout         = in_label2 ? (dead_q ? DEAD_COLOR : LABEL_COLOR) : BAR_COLOR;
    assign bus.hpValue        = hp;
    assign bus.dead           = dead_q;
    assign bus.state_dbg      = state;

endmodule
